// File: rtl/chord_mixer_pkg.sv
// Shared music-synth constants for the chord mixer: sample/sum widths,
// FSM state encoding and 16-bit saturation limits.
package chord_mixer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SUM_W    = 18;
  localparam int N_CH     = 3;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SUM
  } state_t;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/chord_mixer_sat_shift_sum3.sv
// Combinational three-input signed adder with arithmetic right shift,
// saturated back to a 16-bit signed sample.
module sat_shift_sum3
  import chord_mixer_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  input  logic signed [SAMPLE_W-1:0] c,
  output logic signed [SAMPLE_W-1:0] y
);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;
  logic [SUM_W-SAMPLE_W:0] top_bits;

  always_comb begin
    sum = {{(SUM_W-SAMPLE_W){a[SAMPLE_W-1]}}, a}
        + {{(SUM_W-SAMPLE_W){b[SAMPLE_W-1]}}, b}
        + {{(SUM_W-SAMPLE_W){c[SAMPLE_W-1]}}, c};
    shifted  = sum >>> SHIFT;
    // The value fits in 16 bits only when every bit above the 16-bit sign matches it.
    top_bits = shifted[SUM_W-1:SAMPLE_W-1];
    if ((&top_bits) || !(|top_bits)) begin
      y = shifted[SAMPLE_W-1:0];
    end else if (shifted[SUM_W-1]) begin
      y = SAT_MIN;
    end else begin
      y = SAT_MAX;
    end
  end

endmodule

// File: rtl/chord_mixer.sv
// Fans a codec sample request out to three note players, collects one sample
// per active channel (with timeout), then emits their saturated mix.
module chord_mixer
  import chord_mixer_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int SHIFT   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       generate_next,
  input  logic [N_CH-1:0]            ch_active,
  input  logic signed [SAMPLE_W-1:0] ch0_sample,
  input  logic signed [SAMPLE_W-1:0] ch1_sample,
  input  logic signed [SAMPLE_W-1:0] ch2_sample,
  input  logic                       ch0_ready,
  input  logic                       ch1_ready,
  input  logic                       ch2_ready,
  output logic                       gen_next_out,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       out_ready,
  output logic                       timed_out,
  output logic                       overrun
);

  state_t state_reg, state_next;

  logic [N_CH-1:0]            mask_reg;
  logic [N_CH-1:0]            got;
  logic [N_CH-1:0]            ready_vec;
  logic [N_CH-1:0]            complete_vec;
  logic signed [SAMPLE_W-1:0] sample_vec [N_CH];
  logic signed [SAMPLE_W-1:0] cap [N_CH];
  logic [15:0]                tmo_reg;
  logic signed [SAMPLE_W-1:0] mix;
  logic                       accept;
  logic                       complete;
  logic                       last_cycle;

  assign ready_vec     = {ch2_ready, ch1_ready, ch0_ready};
  assign sample_vec[0] = ch0_sample;
  assign sample_vec[1] = ch1_sample;
  assign sample_vec[2] = ch2_sample;

  assign accept     = (state_reg == IDLE) && generate_next;
  assign complete   = &complete_vec;
  assign last_cycle = (tmo_reg == 16'(TIMEOUT - 1));

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic                       got_reg;
      logic signed [SAMPLE_W-1:0] cap_reg;

      always_ff @(posedge clk) begin
        if (reset || accept) begin
          got_reg <= 1'b0;
          cap_reg <= '0;
        end else if (state_reg == COLLECT && mask_reg[gi] && ready_vec[gi]) begin
          got_reg <= 1'b1;
          cap_reg <= sample_vec[gi];
        end
      end

      assign got[gi] = got_reg;
      assign cap[gi] = cap_reg;
      // A strobe in the deciding cycle counts, so the channel is done either way.
      assign complete_vec[gi] = got_reg | ~mask_reg[gi] | (mask_reg[gi] & ready_vec[gi]);
    end
  endgenerate

  sat_shift_sum3 #(.SHIFT(SHIFT)) u_sum (
    .a(cap[0]),
    .b(cap[1]),
    .c(cap[2]),
    .y(mix)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (generate_next) state_next = COLLECT;
      COLLECT: if (complete || last_cycle) state_next = SUM;
      SUM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg     <= '0;
      tmo_reg      <= '0;
      gen_next_out <= 1'b0;
      sample_out   <= '0;
      out_ready    <= 1'b0;
      timed_out    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      gen_next_out <= accept;
      out_ready    <= 1'b0;
      timed_out    <= 1'b0;
      overrun      <= generate_next && (state_reg != IDLE);
      if (accept) begin
        mask_reg <= ch_active;
        tmo_reg  <= '0;
      end
      if (state_reg == COLLECT) tmo_reg <= tmo_reg + 16'd1;
      if (state_reg == SUM) begin
        sample_out <= mix;
        out_ready  <= 1'b1;
        timed_out  <= |(mask_reg & ~got);
      end
    end
  end

endmodule

// File: doc/chord_mixer.md
# chord_mixer

Upstream stage of the echo block in the music-synth audio path. It fans out each codec sample request to three note-player channels and collects one sample from every active channel, with a timeout. It then sums, scales and saturates the collected samples into one 16-bit signed sample. That sample is presented with a one-cycle `out_ready` strobe, which is exactly the `sample_in`/`in_ready` contract the echo stage consumes.

## Interface
- `TIMEOUT`, default 1024: maximum number of COLLECT cycles per request (≥1, ≤65535).
- `SHIFT`, default 0: arithmetic right shift applied to the 18-bit sum before saturation (0–2).
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `generate_next` in 1: one-cycle sample request from the codec side.
- `ch_active` in 3: channel enable mask, latched when a request is accepted.
- `ch0_sample`, `ch1_sample`, `ch2_sample` in 16 each: signed channel samples.
- `ch0_ready`, `ch1_ready`, `ch2_ready` in 1 each: channel sample-valid strobes.
- `gen_next_out` out 1: one-cycle request pulse to all channels.
- `sample_out` out 16: signed mixed sample; held between strobes.
- `out_ready` out 1: one-cycle strobe, `sample_out` valid.
- `timed_out` out 1: pulses together with `out_ready` when at least one active channel was missing.
- `overrun` out 1: one-cycle pulse when `generate_next` arrives outside IDLE.

## Operation
- FSM with three states: IDLE, COLLECT, SUM.
- **IDLE.** When `generate_next` is high:
  - latch `ch_active` into `mask_q`;
  - clear the `got[2:0]` flags and the three capture registers;
  - clear the timeout counter;
  - register `gen_next_out` high for the next cycle;
  - go to COLLECT.
- **COLLECT.**
  - For each channel i with `mask_q[i]` high and `chi_ready` high: capture the sample and set `got[i]`. Later strobes on an already-captured channel overwrite the capture.
  - Ready strobes on masked-off channels are ignored, and those channels contribute 0.
  - `complete` = for all i, (`got[i]` | `~mask_q[i]` | (`mask_q[i]` & `chi_ready`)).
  - If `complete`, or this is the TIMEOUT-th COLLECT cycle, go to SUM. Captures made in that same cycle count.
- **SUM.**
  - Sign-extend the three captures to 18 bits and add them.
  - Arithmetic-shift the result right by SHIFT.
  - Saturate to [-32768, 32767].
  - Register the result into `sample_out`, set `out_ready` for one cycle, and return to IDLE.
  - Set `timed_out` with the strobe if any `mask_q[i]` & ~`got[i]` held on leaving COLLECT.
- `generate_next` in COLLECT or SUM: the request is dropped, `overrun` pulses the next cycle, and the state is unaffected.
- `ch_active` changes after acceptance have no effect until the next request.
- `ch_ready` in IDLE or SUM is ignored.

## Timing
- **Reset values.** State IDLE, `sample_out`=0, and `out_ready`, `gen_next_out`, `timed_out`, `overrun` all 0. Captures and `got` are cleared.
- **Reset mid-operation.** The pending request is abandoned and no `out_ready` follows.
- **Request path.** `generate_next` is seen in cycle T:
  - `gen_next_out` is high in T+1 only;
  - COLLECT starts in T+1.
- **Normal completion.** If the last required ready is seen in cycle C (C ≥ T+1): SUM is in C+1 and `out_ready` is high in C+2.
- **Mask 000.** `complete` is true in T+1, SUM is in T+2, and `out_ready` is high in T+3 with `sample_out`=0.
- **Timeout.** COLLECT occupies T+1 … T+TIMEOUT at most. SUM is then at T+TIMEOUT+1 and `out_ready` at T+TIMEOUT+2.
- `out_ready` is never high on consecutive cycles. The next request can be accepted in the cycle `out_ready` is high.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package (music-synth constants):
  - SAMPLE_W=16;
  - SUM_W=18;
  - state localparams IDLE/COLLECT/SUM;
  - saturation limits 16'sh7FFF / 16'sh8000.
- One sub-module, `sat_shift_sum3`: a combinational 3-input signed sum with SHIFT, followed by saturation to 16 bits. It is unit-testable on its own.
- Per-channel capture logic is identical. Generate it, or write it once per channel.

## Test plan
1. Basic mix. Mask 111, SHIFT=0, samples 1000/2000/-500, readies at T+2/T+3/T+4 -> `gen_next_out` at T+1, `out_ready` at T+6, `sample_out`=2500, `timed_out`=0.
2. Saturation:
   - 30000×3 -> 32767;
   - -30000×3 -> -32768;
   - with SHIFT=2, 30000×3 -> 22500.
3. Timeout. TIMEOUT=8, ch2 never ready, ch0=100 and ch1=200 at T+2 -> `out_ready` at T+10, `sample_out`=300, `timed_out`=1.
4. Masking:
   - mask 000 -> `out_ready` at T+3 with 0;
   - mask 101 with ch1 ready at 7000 -> ch1 is ignored and output = ch0+ch2;
   - changing `ch_active` during COLLECT has no effect.
5. Overrun and reset:
   - `generate_next` during COLLECT -> `overrun` pulse and a single `out_ready` only;
   - `reset` during COLLECT -> no `out_ready`, all outputs 0, and the next request works normally.
6. Back-to-back. `generate_next` on the cycle `out_ready` is high -> accepted, no `overrun`, and the second sample is correct.
